// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, cmd field positions, state codes and helpers shared by the SDRAM sequencer.
package sdram_pkg;
   localparam int CMD_OP_HI = 6;
   localparam int CMD_OP_LO = 3;
   localparam int CMD_BA_HI = 2;
   localparam int CMD_BA_LO = 1;
   localparam int CMD_A10   = 0;
   localparam logic [7:0] CMD_NOP = 8'b1_0_111_000;
   localparam logic [7:0] CMD_PRE = 8'b1_0_010_001;
   localparam logic [7:0] CMD_REF = 8'b1_0_001_000;
   localparam logic [7:0] CMD_MRS = 8'b1_0_000_000;
   localparam logic [7:0] CMD_ACT = 8'b1_0_011_000;
   localparam logic [7:0] CMD_WR  = 8'b1_0_100_000;
   localparam logic [7:0] CMD_RD  = 8'b1_0_101_000;
   localparam logic [4:0] ST_INIT_PRE = 5'b01000;
   localparam logic [4:0] ST_INIT_REF = 5'b01001;
   localparam logic [4:0] ST_INIT_MRS = 5'b01010;
   localparam logic [4:0] ST_IDLE     = 5'b00000;
   localparam logic [4:0] ST_REF      = 5'b00001;
   localparam logic [4:0] ST_ACT      = 5'b10000;
   localparam logic [4:0] ST_WRITE    = 5'b11000;
   localparam logic [4:0] ST_READ     = 5'b10001;
   localparam logic [4:0] ST_PRE      = 5'b00010;
   typedef enum logic [3:0] {
      S_RST, S_IPRE, S_IREF, S_IMRS, S_IDLE, S_REF, S_ACT, S_WR, S_RD, S_PRE
   } fsm_t;
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
   function automatic logic [7:0] cmd_with(input logic [7:0] base, input logic [1:0] ba, input logic a10);
      logic [7:0] c;
      c = base;
      c[CMD_BA_HI:CMD_BA_LO] = ba;
      c[CMD_A10] = a10;
      return c;
   endfunction
endpackage

// File: rtl/sdram_rd_pipe.sv
// sdram_rd_pipe: delays the RD-issued pulse by the CAS latency and stretches it into BURST_LEN rd_valid beats.
module sdram_rd_pipe
   import sdram_pkg::*;
#(
   parameter int T_CL      = 2,
   parameter int BURST_LEN = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rd_go,
   output logic o_rd_valid
);
   logic [T_CL-1:0] r_sh;
   logic [3:0]      r_beats;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh    <= '0;
         r_beats <= '0;
      end else begin
         r_sh    <= T_CL'({r_sh, i_rd_go});
         r_beats <= r_sh[T_CL-1] ? 4'(BURST_LEN - 1) : ((r_beats != '0) ? r_beats - 4'd1 : '0);
      end
   end
   assign o_rd_valid = r_sh[T_CL-1] | (r_beats != '0);
endmodule

// File: rtl/sdram_ctrl_fsm.sv
// sdram_ctrl_fsm: parametrised SDRAM init/refresh/read/write command sequencer with a single wait timer.
// Define SDRAM_AUTO_PRECHARGE_EN to close rows with A10 auto-precharge instead of an explicit PRE.
module sdram_ctrl_fsm
   import sdram_pkg::*;
#(
   parameter int T_RP           = 2,
   parameter int T_RFC          = 8,
   parameter int T_RCD          = 2,
   parameter int T_WR           = 2,
   parameter int T_CL           = 2,
   parameter int T_MRD          = 2,
   parameter int BURST_LEN      = 1,
   parameter int INIT_REFRESHES = 2,
   parameter int REFRESH_THRESH = 519,
   parameter int CNT_W          = 10
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [CNT_W-1:0] refresh_cnt,
   input  logic             wr_enable,
   input  logic             rd_enable,
   input  logic [1:0]       bank,
   output logic             ready,
   output logic             refresh_ack,
   output logic [7:0]       cmd,
   output logic             rd_valid,
   output logic [4:0]       state
);
`ifdef SDRAM_AUTO_PRECHARGE_EN
   localparam logic AP      = 1'b1;
   localparam int   WR_HOLD = T_WR + T_RP;
   localparam int   RD_HOLD = max2(BURST_LEN + T_RP, T_CL + BURST_LEN);
`else
   localparam logic AP      = 1'b0;
   localparam int   WR_HOLD = T_WR;
   localparam int   RD_HOLD = max2(BURST_LEN, T_CL + BURST_LEN - T_RP);
`endif
   // Hold times count the command cycle itself; the last read beat always precedes IDLE.
   localparam int HOLD_MAX = max2(max2(max2(T_RP, T_RFC), max2(T_RCD, T_MRD)), max2(WR_HOLD, RD_HOLD));
   localparam int TW = $clog2(HOLD_MAX + 1);
   localparam int IW = $clog2(INIT_REFRESHES + 1);
   fsm_t          r_st, w_st_nxt;
   logic [7:0]    r_cmd, w_cmd_nxt;
   logic [TW-1:0] r_tmr, w_tmr_nxt;
   logic [IW-1:0] r_iref, w_iref_nxt;
   logic [1:0]    r_bank, w_bank_nxt;
   logic          r_wr, w_wr_nxt;
   logic          r_ack, w_ack_nxt;
   logic          w_due;
   logic          w_rd_go;
   logic [4:0]    w_code;
   assign w_due = refresh_cnt >= CNT_W'(REFRESH_THRESH);
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_st   <= S_RST;
         r_cmd  <= CMD_NOP;
         r_tmr  <= '0;
         r_iref <= '0;
         r_bank <= '0;
         r_wr   <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         r_st   <= w_st_nxt;
         r_cmd  <= w_cmd_nxt;
         r_tmr  <= w_tmr_nxt;
         r_iref <= w_iref_nxt;
         r_bank <= w_bank_nxt;
         r_wr   <= w_wr_nxt;
         r_ack  <= w_ack_nxt;
      end
   end
   always_comb begin
      w_st_nxt   = r_st;
      w_cmd_nxt  = CMD_NOP;
      w_tmr_nxt  = (r_tmr != '0) ? r_tmr - TW'(1) : '0;
      w_iref_nxt = r_iref;
      w_bank_nxt = r_bank;
      w_wr_nxt   = r_wr;
      w_ack_nxt  = 1'b0;
      if (r_tmr == '0) begin
         case (r_st)
            S_RST: begin
               w_st_nxt  = S_IPRE;
               w_cmd_nxt = CMD_PRE;
               w_tmr_nxt = TW'(T_RP - 1);
            end
            S_IPRE: begin
               w_st_nxt  = S_IREF;
               w_cmd_nxt = CMD_REF;
               w_tmr_nxt = TW'(T_RFC - 1);
            end
            S_IREF: begin
               if (r_iref == IW'(INIT_REFRESHES - 1)) begin
                  w_st_nxt  = S_IMRS;
                  w_cmd_nxt = CMD_MRS;
                  w_tmr_nxt = TW'(T_MRD - 1);
               end else begin
                  w_cmd_nxt  = CMD_REF;
                  w_tmr_nxt  = TW'(T_RFC - 1);
                  w_iref_nxt = r_iref + IW'(1);
               end
            end
            S_IDLE: begin
               if (w_due) begin
                  w_st_nxt  = S_REF;
                  w_cmd_nxt = CMD_REF;
                  w_tmr_nxt = TW'(T_RFC - 1);
                  w_ack_nxt = 1'b1;
               end else if (wr_enable | rd_enable) begin
                  w_st_nxt   = S_ACT;
                  w_cmd_nxt  = cmd_with(CMD_ACT, bank, 1'b0);
                  w_tmr_nxt  = TW'(T_RCD - 1);
                  w_bank_nxt = bank;
                  w_wr_nxt   = wr_enable;
               end
            end
            S_ACT: begin
               w_st_nxt  = r_wr ? S_WR : S_RD;
               w_cmd_nxt = cmd_with(r_wr ? CMD_WR : CMD_RD, r_bank, AP);
               w_tmr_nxt = r_wr ? TW'(WR_HOLD - 1) : TW'(RD_HOLD - 1);
            end
`ifdef SDRAM_AUTO_PRECHARGE_EN
            S_WR, S_RD: w_st_nxt = S_IDLE;
`else
            S_WR, S_RD: begin
               w_st_nxt  = S_PRE;
               w_cmd_nxt = CMD_PRE;
               w_tmr_nxt = TW'(T_RP - 1);
            end
`endif
            S_IMRS, S_REF, S_PRE: w_st_nxt = S_IDLE;
            default: w_st_nxt = S_RST;
         endcase
      end
   end
   always_comb begin
      w_code = ST_INIT_PRE;
      case (r_st)
         S_IREF:  w_code = ST_INIT_REF;
         S_IMRS:  w_code = ST_INIT_MRS;
         S_IDLE:  w_code = ST_IDLE;
         S_REF:   w_code = ST_REF;
         S_ACT:   w_code = ST_ACT;
         S_WR:    w_code = ST_WRITE;
         S_RD:    w_code = ST_READ;
         S_PRE:   w_code = ST_PRE;
         default: w_code = ST_INIT_PRE;
      endcase
   end
   assign w_rd_go     = (r_st == S_RD) && (r_cmd[CMD_OP_HI:CMD_OP_LO] == CMD_RD[CMD_OP_HI:CMD_OP_LO]);
   assign ready       = (r_st == S_IDLE) & ~w_due;
   assign refresh_ack = r_ack;
   assign cmd         = r_cmd;
   assign state       = w_code;
   sdram_rd_pipe #(.T_CL(T_CL), .BURST_LEN(BURST_LEN)) u_rd_pipe (
      .i_clk      (CLK),
      .i_rst_n    (RESET),
      .i_rd_go    (w_rd_go),
      .o_rd_valid (rd_valid)
   );
endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// tb_sdram_ctrl_fsm: cycle-by-cycle vector table plus a hand-written mid-burst reset sequence.
module tb_sdram_ctrl_fsm;
   localparam logic [7:0] NOP = 8'b1_0_111_000;
   localparam logic [7:0] PRE = 8'b1_0_010_001;
   localparam logic [7:0] REF = 8'b1_0_001_000;
   localparam logic [7:0] MRS = 8'b1_0_000_000;
   localparam logic [4:0] C_IPRE = 5'b01000, C_IREF = 5'b01001, C_IMRS = 5'b01010, C_IDLE = 5'b00000;
   localparam logic [4:0] C_REF = 5'b00001, C_ACT = 5'b10000, C_WR = 5'b11000, C_RD = 5'b10001, C_PRE = 5'b00010;
`ifdef SDRAM_AUTO_PRECHARGE_EN
   localparam logic AP = 1'b1;
`else
   localparam logic AP = 1'b0;
`endif
   typedef struct {
      logic       wr;
      logic       rd;
      logic [1:0] bk;
      logic [9:0] rc;
      logic [7:0] cmd;
      logic [4:0] st;
      logic       rdy;
      logic       ack;
      logic       rdv;
   } vec_t;
   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [9:0] refresh_cnt = '0;
   logic       wr_enable = 1'b0;
   logic       rd_enable = 1'b0;
   logic [1:0] bank = '0;
   logic       ready, refresh_ack, rd_valid;
   logic [7:0] cmd;
   logic [4:0] state;
   vec_t       q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         n_init;
   always #5 CLK = ~CLK;
   sdram_ctrl_fsm #(.T_CL(3), .BURST_LEN(4)) dut (
      .CLK(CLK), .RESET(RESET), .refresh_cnt(refresh_cnt), .wr_enable(wr_enable),
      .rd_enable(rd_enable), .bank(bank), .ready(ready), .refresh_ack(refresh_ack),
      .cmd(cmd), .rd_valid(rd_valid), .state(state)
   );
   function automatic void add(input logic wr, input logic rd, input logic [1:0] bk, input logic [9:0] rc,
                               input logic [7:0] c, input logic [4:0] st, input logic rdy, input logic ack,
                               input logic rdv);
      vec_t v;
      v.wr = wr; v.rd = rd; v.bk = bk; v.rc = rc; v.cmd = c; v.st = st; v.rdy = rdy; v.ack = ack; v.rdv = rdv;
      q.push_back(v);
   endfunction
   function automatic void nops(input int n, input logic wr, input logic rd, input logic [1:0] bk, input logic [4:0] st);
      for (int i = 0; i < n; i++) add(wr, rd, bk, 10'd0, NOP, st, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic void acc(input logic wr, input logic rd, input logic [1:0] bk);
      add(wr, rd, bk, 10'd0, NOP, C_IDLE, 1'b1, 1'b0, 1'b0);
   endfunction
   // ACT, T_RCD-1 NOPs, WR, then either T_WR+T_RP-1 NOPs or T_WR-1 NOPs + PRE + T_RP-1 NOPs.
   function automatic void wr_body(input logic [1:0] bk, input logic rd_hold);
      add(1'b0, rd_hold, ~bk, 10'd0, {5'b10011, bk, 1'b0}, C_ACT, 1'b0, 1'b0, 1'b0);
      nops(1, 1'b0, rd_hold, ~bk, C_ACT);
      add(1'b0, rd_hold, ~bk, 10'd0, {5'b10100, bk, AP}, C_WR, 1'b0, 1'b0, 1'b0);
      if (AP) nops(3, 1'b0, rd_hold, ~bk, C_WR);
      else begin
         nops(1, 1'b0, rd_hold, ~bk, C_WR);
         add(1'b0, rd_hold, ~bk, 10'd0, PRE, C_PRE, 1'b0, 1'b0, 1'b0);
         nops(1, 1'b0, rd_hold, ~bk, C_PRE);
      end
   endfunction
   // T_CL=3, BURST_LEN=4: beats on RD+3..RD+6, IDLE no earlier than RD+7.
   function automatic void rd_body(input logic [1:0] bk);
      add(1'b0, 1'b0, ~bk, 10'd0, {5'b10011, bk, 1'b0}, C_ACT, 1'b0, 1'b0, 1'b0);
      nops(1, 1'b0, 1'b0, ~bk, C_ACT);
      add(1'b0, 1'b0, ~bk, 10'd0, {5'b10101, bk, AP}, C_RD, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k < 7; k++)
         add(1'b0, 1'b0, ~bk, 10'd0, (!AP && k == 5) ? PRE : NOP, (!AP && k >= 5) ? C_PRE : C_RD,
             1'b0, 1'b0, k >= 3);
   endfunction
   task automatic run(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         wr_enable = q[i].wr; rd_enable = q[i].rd; bank = q[i].bk; refresh_cnt = q[i].rc;
         #1;
         n_vec++;
         if ({cmd, state, ready, refresh_ack, rd_valid} !== {q[i].cmd, q[i].st, q[i].rdy, q[i].ack, q[i].rdv}) begin
            n_bad++;
            $display("FAIL vec%0d: got cmd=%b state=%b rdy=%b ack=%b rdv=%b, want cmd=%b state=%b rdy=%b ack=%b rdv=%b",
                     i, cmd, state, ready, refresh_ack, rd_valid, q[i].cmd, q[i].st, q[i].rdy, q[i].ack, q[i].rdv);
         end
         @(negedge CLK);
      end
   endtask
   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask
   initial begin
      int cyc;
      add(1'b0, 1'b0, 2'd0, 10'd0, NOP, C_IPRE, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 2'd0, 10'd0, PRE, C_IPRE, 1'b0, 1'b0, 1'b0);
      nops(1, 1'b0, 1'b0, 2'd0, C_IPRE);
      for (int r = 0; r < 2; r++) begin
         add(1'b1, 1'b1, 2'd0, 10'd0, REF, C_IREF, 1'b0, 1'b0, 1'b0);
         nops(7, 1'b1, 1'b1, 2'd0, C_IREF);
      end
      add(1'b0, 1'b0, 2'd0, 10'd0, MRS, C_IMRS, 1'b0, 1'b0, 1'b0);
      nops(1, 1'b0, 1'b0, 2'd0, C_IMRS);
      n_init = q.size();
      acc(1'b1, 1'b0, 2'd2);
      wr_body(2'd2, 1'b0);
      acc(1'b0, 1'b1, 2'd1);
      rd_body(2'd1);
      add(1'b0, 1'b0, 2'd0, 10'd518, NOP, C_IDLE, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 2'd0, 10'd0, NOP, C_IDLE, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'd3, 10'd519, NOP, C_IDLE, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 2'd3, 10'd0, REF, C_REF, 1'b0, 1'b1, 1'b0);
      nops(7, 1'b1, 1'b0, 2'd3, C_REF);
      acc(1'b1, 1'b0, 2'd3);
      wr_body(2'd3, 1'b0);
      acc(1'b1, 1'b1, 2'd0);
      wr_body(2'd0, 1'b1);
      acc(1'b0, 1'b1, 2'd0);
      rd_body(2'd0);
      acc(1'b0, 1'b0, 2'd0);
      // The last entry was just an IDLE pass; it must not have started anything.
      add(1'b0, 1'b0, 2'd0, 10'd0, NOP, C_IDLE, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      #1;
      check("reset_values", {cmd, state, ready, refresh_ack, rd_valid, 1'b0},
            {NOP, C_IPRE, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge CLK);
      RESET = 1'b1;
      run(0, q.size());
      rd_enable = 1'b1;
      bank = 2'd2;
      cyc = 0;
      while (!rd_valid && cyc < 20) begin
         @(negedge CLK);
         #1;
         cyc++;
         rd_enable = 1'b0;
      end
      check("first_beat_latency", 16'(cyc), 16'd6);
      #1 RESET = 1'b0;
      #1;
      check("async_reset_midburst", {cmd, state, ready, refresh_ack, rd_valid, 1'b0},
            {NOP, C_IPRE, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge CLK);
      RESET = 1'b1;
      run(0, n_init);
      #1;
      check("replay_ready", {11'd0, state}, {11'd0, C_IDLE});
      check("replay_ready_flag", {15'd0, ready}, 16'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
endmodule
